// File: rtl/rsa_pkg.sv
// Shared constants and state encoding for the modular-exponentiation sequencer.
package rsa_pkg;

    localparam int W_DEFAULT = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_MUL,
        S_WAIT_M,
        S_SQR,
        S_WAIT_T,
        S_DONE
    } seq_state_e;

endpackage

// File: rtl/rsa_exp_sequencer_if.sv
// Host and Montgomery-multiplier handshake bundle for rsa_exp_sequencer.
interface rsa_exp_sequencer_if #(
    parameter int W = rsa_pkg::W_DEFAULT
) ();

    logic         i_start;
    logic [W-1:0] i_a;
    logic [W-1:0] i_d;
    logic [W-1:0] i_n;
    logic [W-1:0] o_a_pow_d;
    logic         o_finished;
    logic         o_busy;
    logic         o_mm_start;
    logic [W-1:0] o_mm_a;
    logic [W-1:0] o_mm_b;
    logic [W-1:0] o_mm_n;
    logic [W-1:0] i_mm_m;
    logic         i_mm_finished;

    modport slave (
        input  i_start, i_a, i_d, i_n, i_mm_m, i_mm_finished,
        output o_a_pow_d, o_finished, o_busy, o_mm_start, o_mm_a, o_mm_b, o_mm_n
    );

    modport master (
        output i_start, i_a, i_d, i_n, i_mm_m, i_mm_finished,
        input  o_a_pow_d, o_finished, o_busy, o_mm_start, o_mm_a, o_mm_b, o_mm_n
    );

endinterface

// File: rtl/rsa_exp_sequencer_mod_prescale.sv
// Shift-subtract pre-scale: after W doubling steps o_t = a*2^W mod N, o_done pulses on the last step.
module mod_prescale
    import rsa_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_n,
    output logic         o_done,
    output logic [W-1:0] o_t
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_run;
    logic [W:0]    w_dbl;
    logic          w_ge;
    logic [W-1:0]  w_next;

    // Accumulator stays below N, so 2*acc fits W+1 bits and the W-bit difference is exact
    assign w_dbl  = {r_acc, 1'b0};
    assign w_ge   = (w_dbl >= {1'b0, i_n});
    assign w_next = w_ge ? (w_dbl[W-1:0] - i_n) : w_dbl[W-1:0];
    assign o_done = r_run && (r_cnt == CW'(W - 1));
    assign o_t    = w_next;

    // i_n is the parent's latched modulus, valid from the first doubling cycle onward
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_acc <= i_a;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_acc <= w_next;
            r_cnt <= r_cnt + CW'(1);
            if (o_done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rsa_exp_sequencer.sv
// Right-to-left square-and-multiply controller computing a^d mod N with an external Montgomery multiplier.
// Optional macro RSA_SEQ_SKIP_ZERO_EN ends the loop once the remaining exponent bits are all zero.
module rsa_exp_sequencer
    import rsa_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input logic                i_clk,
    input logic                i_rst_n,
    rsa_exp_sequencer_if.slave bus
);

    localparam int IW = $clog2(W);

    seq_state_e    r_state;
    seq_state_e    w_next;
    logic [W-1:0]  r_d;
    logic [W-1:0]  r_n;
    logic [W-1:0]  r_t;
    logic [W-1:0]  r_m;
    logic [W-1:0]  r_result;
    logic [IW-1:0] r_idx;
    logic          w_lastIdx;
    logic          w_restZero;
    logic          w_tailZero;
    logic          w_dZero;
    logic          w_preStart;
    logic          w_preDone;
    logic [W-1:0]  w_preT;
    logic          w_mmStart;

    assign w_lastIdx = (r_idx == IW'(W - 1));

`ifdef RSA_SEQ_SKIP_ZERO_EN
    logic [IW:0] w_idxInc;
    assign w_idxInc   = {1'b0, r_idx} + (IW + 1)'(1);
    assign w_restZero = ((r_d >> r_idx) == '0);
    assign w_tailZero = ((r_d >> w_idxInc) == '0);
    assign w_dZero    = (bus.i_d == '0);
`else
    assign w_restZero = 1'b0;
    assign w_tailZero = 1'b0;
    assign w_dZero    = 1'b0;
`endif

    assign w_preStart = (r_state == S_IDLE) && bus.i_start && !w_dZero;

    mod_prescale #(.W(W)) u_prescale (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (w_preStart),
        .i_a     (bus.i_a),
        .i_n     (r_n),
        .o_done  (w_preDone),
        .o_t     (w_preT)
    );

    always_comb begin
        w_next    = r_state;
        w_mmStart = 1'b0;
        case (r_state)
            S_IDLE:   if (bus.i_start) w_next = w_dZero ? S_DONE : S_PREP;
            S_PREP:   if (w_preDone) w_next = S_MUL;
            S_MUL: begin
                if (w_restZero) begin
                    w_next = S_DONE;
                end else if (r_d[r_idx]) begin
                    w_mmStart = 1'b1;
                    w_next    = S_WAIT_M;
                end else begin
                    w_next = S_SQR;
                end
            end
            S_WAIT_M: if (bus.i_mm_finished) w_next = w_tailZero ? S_DONE : S_SQR;
            S_SQR: begin
                w_mmStart = 1'b1;
                w_next    = S_WAIT_T;
            end
            S_WAIT_T: if (bus.i_mm_finished) w_next = w_lastIdx ? S_DONE : S_MUL;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // m stays in the normal domain because MM(m, t) with t = a*2^W cancels the 2^-W factor
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_d      <= '0;
            r_n      <= '0;
            r_t      <= '0;
            r_m      <= '0;
            r_result <= '0;
            r_idx    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_d   <= bus.i_d;
                        r_n   <= bus.i_n;
                        r_t   <= bus.i_a;
                        r_m   <= W'(1);
                        r_idx <= '0;
                    end
                end
                S_PREP:   if (w_preDone) r_t <= w_preT;
                S_WAIT_M: if (bus.i_mm_finished) r_m <= bus.i_mm_m;
                S_WAIT_T: begin
                    if (bus.i_mm_finished) begin
                        r_t <= bus.i_mm_m;
                        if (!w_lastIdx) begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                S_DONE:   r_result <= r_m;
                default:  ;
            endcase
        end
    end

    assign bus.o_mm_start = w_mmStart;
    assign bus.o_busy     = (r_state != S_IDLE);
    assign bus.o_finished = (r_state == S_DONE);
    assign bus.o_a_pow_d  = (r_state == S_DONE) ? r_m : r_result;
    assign bus.o_mm_a     = (r_state == S_MUL || r_state == S_WAIT_M) ? r_m :
                            (r_state == S_SQR || r_state == S_WAIT_T) ? r_t : '0;
    assign bus.o_mm_b     = (r_state == S_MUL || r_state == S_WAIT_M ||
                             r_state == S_SQR || r_state == S_WAIT_T) ? r_t : '0;
    assign bus.o_mm_n     = r_n;

endmodule

// File: tb/tb_rsa_exp_sequencer.sv
// Directed and randomized bench for rsa_exp_sequencer with a behavioural Montgomery multiplier on the mm_* side.
module tb_rsa_exp_sequencer;
    import rsa_pkg::*;

    localparam int W     = W_DEFAULT;
    localparam int LIMIT = 8000;

    logic clk;
    logic rstN;
    int   compared   = 0;
    int   mismatched = 0;
    int   mmStarts   = 0;
    int   stableErr  = 0;
    int   overlapErr = 0;

    logic [W-1:0] capA, capB, capN;
    bit           pending;
    int           waitLeft;

    rsa_exp_sequencer_if #(.W(W)) bus ();

    rsa_exp_sequencer #(.W(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-serial Montgomery product x*y*2^-W mod n
    function automatic logic [W-1:0] montMul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] n);
        logic [W+1:0] u;
        u = '0;
        for (int i = 0; i < W; i++) begin
            if (x[i]) u = u + {2'b00, y};
            if (u[0]) u = u + {2'b00, n};
            u = u >> 1;
        end
        if (u >= {2'b00, n}) u = u - {2'b00, n};
        return u[W-1:0];
    endfunction

    function automatic logic [W-1:0] refModExp(input logic [W-1:0] a, input logic [W-1:0] d,
                                               input logic [W-1:0] n);
        logic [2*W-1:0] r, b, nn;
        r  = (2*W)'(1);
        b  = {{W{1'b0}}, a};
        nn = {{W{1'b0}}, n};
        for (int i = 0; i < W; i++) begin
            if (d[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[W-1:0];
    endfunction

    function automatic int expMmCount(input logic [W-1:0] d);
        int pop;
        int top;
        pop = 0;
        top = -1;
        for (int i = 0; i < W; i++) begin
            if (d[i]) begin
                pop++;
                top = i;
            end
        end
`ifdef RSA_SEQ_SKIP_ZERO_EN
        return (top < 0) ? 0 : top + pop;
`else
        return W + pop;
`endif
    endfunction

    function automatic logic [W-1:0] randWide();
        logic [W-1:0] v;
        for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    // Multiplier responder: random 1-2 cycle latency, also watches operand stability and overlap
    initial begin
        bus.i_mm_finished = 1'b0;
        bus.i_mm_m        = '0;
        pending           = 1'b0;
        waitLeft          = 0;
        forever begin
            @(negedge clk);
            bus.i_mm_finished = 1'b0;
            if (!rstN) begin
                pending = 1'b0;
                continue;
            end
            if (pending) begin
                if (bus.o_mm_a !== capA || bus.o_mm_b !== capB) stableErr++;
                if (bus.o_mm_start) overlapErr++;
                waitLeft--;
                if (waitLeft == 0) begin
                    bus.i_mm_m        = montMul(capA, capB, capN);
                    bus.i_mm_finished = 1'b1;
                    pending           = 1'b0;
                end
            end else if (bus.o_mm_start) begin
                mmStarts++;
                capA     = bus.o_mm_a;
                capB     = bus.o_mm_b;
                capN     = bus.o_mm_n;
                waitLeft = $urandom_range(1, 2);
                pending  = 1'b1;
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] d, input logic [W-1:0] n,
                                 output logic [W-1:0] res, output int finCount, output int mmUsed,
                                 output bit timedOut, output logic busyFirst, output logic busyAfter);
        int startBase;
        int cyc;
        res      = '0;
        finCount = 0;
        timedOut = 1'b0;
        @(negedge clk);
        startBase   = mmStarts;
        bus.i_start = 1'b1;
        bus.i_a     = a;
        bus.i_d     = d;
        bus.i_n     = n;
        @(negedge clk);
        bus.i_start = 1'b0;
        busyFirst   = bus.o_busy;
        cyc         = 0;
        while (finCount == 0 && cyc < LIMIT) begin
            if (bus.o_finished) begin
                finCount++;
                res = bus.o_a_pow_d;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (finCount == 0) timedOut = 1'b1;
        @(negedge clk);
        busyAfter = bus.o_busy;
        if (bus.o_finished) finCount++;
        repeat (3) begin
            @(negedge clk);
            if (bus.o_finished) finCount++;
        end
        mmUsed = mmStarts - startBase;
    endtask

    task automatic test_reset();
        rstN        = 1'b0;
        bus.i_start = 1'b0;
        bus.i_a     = '0;
        bus.i_d     = '0;
        bus.i_n     = '0;
        repeat (3) @(negedge clk);
        compared++;
        if ({bus.o_busy, bus.o_finished, bus.o_mm_start} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got %b expected 000", {bus.o_busy, bus.o_finished, bus.o_mm_start});
        end
        compared++;
        if (bus.o_a_pow_d !== '0 || bus.o_mm_n !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: got pow=%0h n=%0h expected 0", bus.o_a_pow_d, bus.o_mm_n);
        end
        compared++;
        if (bus.o_mm_a !== '0 || bus.o_mm_b !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_operands: got a=%0h b=%0h expected 0", bus.o_mm_a, bus.o_mm_b);
        end
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_textbook();
        logic [W-1:0] res;
        int fin, used;
        bit tmo;
        logic bFirst, bAfter;
        applyStimulus(W'(65), W'(17), W'(3233), res, fin, used, tmo, bFirst, bAfter);
        compared++;
        if (tmo || res !== W'(2790)) begin
            mismatched++;
            $display("[TB] FAIL textbook_result: got %0d expected 2790 (timeout=%0d)", res, tmo);
        end
        compared++;
        if (fin !== 1) begin
            mismatched++;
            $display("[TB] FAIL textbook_finished: got %0d pulses expected 1", fin);
        end
        compared++;
        if (used !== expMmCount(W'(17))) begin
            mismatched++;
            $display("[TB] FAIL textbook_mm_count: got %0d expected %0d", used, expMmCount(W'(17)));
        end
        compared++;
        if (bFirst !== 1'b1 || bAfter !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL textbook_busy: got first=%b after=%b expected 1/0", bFirst, bAfter);
        end
    endtask

    task automatic test_small_vectors();
        logic [W-1:0] va[3], vd[3], vn[3], vr[3];
        logic [W-1:0] res;
        int fin, used;
        bit tmo;
        logic bFirst, bAfter;
        va[0] = W'(2); vd[0] = W'(10); vn[0] = W'(1000003); vr[0] = W'(1024);
        va[1] = W'(5); vd[1] = W'(0);  vn[1] = W'(3233);    vr[1] = W'(1);
        va[2] = W'(7); vd[2] = W'(1);  vn[2] = W'(3233);    vr[2] = W'(7);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(va[i], vd[i], vn[i], res, fin, used, tmo, bFirst, bAfter);
            compared++;
            if (tmo || res !== vr[i] || fin !== 1) begin
                mismatched++;
                $display("[TB] FAIL small_result[%0d]: got %0d (fin=%0d) expected %0d", i, res, fin, vr[i]);
            end
            compared++;
            if (used !== expMmCount(vd[i])) begin
                mismatched++;
                $display("[TB] FAIL small_mm_count[%0d]: got %0d expected %0d", i, used, expMmCount(vd[i]));
            end
        end
    endtask

    task automatic test_start_while_busy();
        int fin, cyc, base;
        logic [W-1:0] res;
        logic [W-1:0] nSeen;
        fin = 0;
        res = '0;
        @(negedge clk);
        base        = mmStarts;
        bus.i_start = 1'b1;
        bus.i_a     = W'(65);
        bus.i_d     = W'(17);
        bus.i_n     = W'(3233);
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (10) @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_a     = W'(7);
        bus.i_d     = W'(1);
        bus.i_n     = W'(1000003);
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (300) @(negedge clk);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        nSeen       = bus.o_mm_n;
        cyc         = 0;
        while (cyc < LIMIT && bus.o_busy) begin
            if (bus.o_finished) begin
                fin++;
                res = bus.o_a_pow_d;
            end
            @(negedge clk);
            cyc++;
        end
        repeat (3) begin
            if (bus.o_finished) fin++;
            @(negedge clk);
        end
        compared++;
        if (res !== W'(2790) || fin !== 1) begin
            mismatched++;
            $display("[TB] FAIL busy_start_result: got %0d (fin=%0d) expected 2790 (fin=1)", res, fin);
        end
        compared++;
        if (nSeen !== W'(3233)) begin
            mismatched++;
            $display("[TB] FAIL busy_start_modulus: got %0d expected 3233", nSeen);
        end
        compared++;
        if (mmStarts - base !== expMmCount(W'(17))) begin
            mismatched++;
            $display("[TB] FAIL busy_start_mm_count: got %0d expected %0d", mmStarts - base, expMmCount(W'(17)));
        end
    endtask

    task automatic test_reset_mid_op();
        int squares, cyc;
        bit sawFin;
        logic [W-1:0] res;
        int fin, used;
        bit tmo;
        logic bFirst, bAfter;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_a     = W'(65);
        bus.i_d     = W'(17);
        bus.i_n     = W'(3233);
        @(negedge clk);
        bus.i_start = 1'b0;
        squares     = 0;
        cyc         = 0;
        while (squares < 3 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (bus.o_mm_start && bus.o_mm_a === bus.o_mm_b) squares++;
        end
        compared++;
        if (squares < 3) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_reach: got %0d squares expected 3", squares);
        end
        @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        compared++;
        if ({bus.o_busy, bus.o_finished, bus.o_mm_start} !== 3'b000 || bus.o_mm_a !== '0 || bus.o_mm_n !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_outputs: got flags=%b a=%0h n=%0h expected 0",
                     {bus.o_busy, bus.o_finished, bus.o_mm_start}, bus.o_mm_a, bus.o_mm_n);
        end
        sawFin = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.o_finished) sawFin = 1'b1;
        end
        rstN = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.o_finished || bus.o_busy) sawFin = 1'b1;
        end
        compared++;
        if (sawFin !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_abort: got activity=%b expected 0", sawFin);
        end
        applyStimulus(W'(65), W'(17), W'(3233), res, fin, used, tmo, bFirst, bAfter);
        compared++;
        if (tmo || res !== W'(2790) || fin !== 1) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_rerun: got %0d (fin=%0d) expected 2790", res, fin);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, d, n, res, expRes;
        int fin, used;
        bit tmo;
        logic bFirst, bAfter;
        for (int r = 0; r < 16; r++) begin
            n        = randWide();
            n[0]     = 1'b1;
            n[W-1]   = 1'b1;
            a        = randWide() % n;
            d        = randWide();
            if (r == 0) d = W'(3);
            expRes   = refModExp(a, d, n);
            applyStimulus(a, d, n, res, fin, used, tmo, bFirst, bAfter);
            compared++;
            if (tmo || res !== expRes || fin !== 1) begin
                mismatched++;
                $display("[TB] FAIL random_result[%0d]: got %0h expected %0h", r, res, expRes);
            end
            compared++;
            if (used !== expMmCount(d)) begin
                mismatched++;
                $display("[TB] FAIL random_mm_count[%0d]: got %0d expected %0d", r, used, expMmCount(d));
            end
        end
        compared++;
        if (stableErr !== 0 || overlapErr !== 0) begin
            mismatched++;
            $display("[TB] FAIL mm_operand_discipline: got unstable=%0d overlap=%0d expected 0/0", stableErr, overlapErr);
        end
    endtask

    initial begin
        test_reset();
        test_textbook();
        test_small_vectors();
        test_start_while_busy();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
